// File: rtl/timer_pkg.sv
// Shared definitions for the PWM timer and PWM capture blocks:
// register map, FSM state encoding and STATUS bit positions.
package timer_pkg;

    localparam logic [1:0] ADDR_HIGH   = 2'd0;
    localparam logic [1:0] ADDR_PERIOD = 2'd1;
    localparam logic [1:0] ADDR_STOP   = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARM  = 3'd1,
        HIGH = 3'd2,
        LOW  = 3'd3,
        DONE = 3'd4
    } cap_state_t;

    localparam int ST_BUSY    = 0;
    localparam int ST_DONE    = 1;
    localparam int ST_TIMEOUT = 2;
    localparam int ST_CNT_LSB = 8;

endpackage

// File: rtl/pwm_edge_sync.sv
// Brings the asynchronous PWM input into the clock domain and emits
// single-cycle rise/fall pulses with a fixed latency.
module pwm_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_pwm,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   w_sync;

    assign w_sync = r_sync[SYNC_STAGES-1];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pwm};
            r_prev <= w_sync;
        end
    end

    assign o_rise = w_sync & ~r_prev;
    assign o_fall = ~w_sync & r_prev;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and rising-to-rising period of an incoming PWM signal
// over a programmed number of periods; register-mapped on a 2-bit bus.
module pwm_capture
    import timer_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int CYCLE_W     = 7,
    parameter int SYNC_STAGES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [1:0]        i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_pwm,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_rvalid,
    output logic              o_capture_end,
    output logic              o_timeout
);

    cap_state_t         r_state, w_next;
    logic [DATA_W-1:0]  r_run, r_high, r_period, r_rdata;
    logic [CYCLE_W-1:0] r_stop, r_target, r_count;
    logic               r_done, r_timeout, r_rvalid;

    logic               w_rise, w_fall, w_run_max, w_busy;
    logic               w_arm, w_restart, w_lat_high, w_lat_per, w_to, w_end;
    logic [CYCLE_W-1:0] w_count_nxt;
    logic [DATA_W-1:0]  w_run_p1, w_status, w_rd_mux;
    logic               w_unused_wdata;

    pwm_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_pwm   (i_pwm),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    assign w_run_max   = &r_run;
    // A measured length of 2^DATA_W is not representable; clamp instead of wrapping.
    assign w_run_p1    = w_run_max ? r_run : r_run + DATA_W'(1);
    assign w_count_nxt = r_count + CYCLE_W'(1);
    assign w_busy      = (r_state != IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_arm      = 1'b0;
        w_restart  = 1'b0;
        w_lat_high = 1'b0;
        w_lat_per  = 1'b0;
        w_to       = 1'b0;
        w_end      = 1'b0;
        case (r_state)
            IDLE: if (i_start && r_stop != '0) begin
                w_arm  = 1'b1;
                w_next = ARM;
            end
            ARM: if (w_rise) begin
                w_restart = 1'b1;
                w_next    = HIGH;
            end else if (w_run_max) begin
                w_to   = 1'b1;
                w_next = IDLE;
            end
            HIGH: if (w_fall) begin
                w_lat_high = 1'b1;
                w_next     = LOW;
            end else if (w_run_max) begin
                w_to   = 1'b1;
                w_next = IDLE;
            end
            LOW: if (w_rise) begin
                w_lat_per = 1'b1;
                if (w_count_nxt == r_target) begin
                    w_next = DONE;
                end else begin
                    w_restart = 1'b1;
                    w_next    = HIGH;
                end
            end else if (w_run_max) begin
                w_to   = 1'b1;
                w_next = IDLE;
            end
            DONE: begin
                w_end  = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_run     <= '0;
            r_high    <= '0;
            r_period  <= '0;
            r_target  <= '0;
            r_count   <= '0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            if (w_arm) begin
                r_run     <= '0;
                r_count   <= '0;
                r_done    <= 1'b0;
                r_timeout <= 1'b0;
                r_target  <= r_stop;
            end else if (w_restart) begin
                r_run <= '0;
            end else if ((r_state == ARM || r_state == HIGH || r_state == LOW) && !w_run_max) begin
                r_run <= r_run + DATA_W'(1);
            end
            if (w_lat_high) r_high <= w_run_p1;
            if (w_lat_per) begin
                r_period <= w_run_p1;
                r_count  <= w_count_nxt;
            end
            if (w_to)  r_timeout <= 1'b1;
            if (w_end) r_done    <= 1'b1;
        end
    end

    always_comb begin
        w_status                           = '0;
        w_status[ST_BUSY]                  = w_busy;
        w_status[ST_DONE]                  = r_done;
        w_status[ST_TIMEOUT]               = r_timeout;
        w_status[ST_CNT_LSB +: CYCLE_W]    = r_count;
        case (i_addr)
            ADDR_HIGH:   w_rd_mux = r_high;
            ADDR_PERIOD: w_rd_mux = r_period;
            ADDR_STOP:   w_rd_mux = DATA_W'(r_stop);
            default:     w_rd_mux = w_status;
        endcase
    end

    // Read mux samples pre-write state, so a same-cycle STOP write reads back old.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stop   <= '0;
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            if (i_we && i_addr == ADDR_STOP) r_stop <= i_wdata[CYCLE_W-1:0];
            if (i_re) r_rdata <= w_rd_mux;
            r_rvalid <= i_re;
        end
    end

    assign w_unused_wdata = ^i_wdata[DATA_W-1:CYCLE_W];

    assign o_rdata       = r_rdata;
    assign o_rvalid      = r_rvalid;
    assign o_capture_end = w_end;
    assign o_timeout     = r_timeout;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: clean PWM patterns from a phase generator,
// hand-computed HIGH/PERIOD/STATUS values, timeout and reset behaviour.
module tb_pwm_capture;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [15:0] wdata = 16'd0;
    logic        pwm = 1'b0;
    logic [15:0] rdata;
    logic        rvalid, cend, tout;

    int checks = 0;
    int errors = 0;
    int pwm_en = 0, pwm_hi = 0, pwm_per = 1, ph = 0;
    int pulses;
    logic [15:0] st;

    pwm_capture #(.DATA_W(16), .CYCLE_W(7), .SYNC_STAGES(2)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_start       (start),
        .i_we          (we),
        .i_re          (re),
        .i_addr        (addr),
        .i_wdata       (wdata),
        .i_pwm         (pwm),
        .o_rdata       (rdata),
        .o_rvalid      (rvalid),
        .o_capture_end (cend),
        .o_timeout     (tout)
    );

    always #5 clk = ~clk;

    // Phase generator: high for pwm_hi clocks out of every pwm_per.
    always @(negedge clk) begin
        if (pwm_en == 0) begin
            ph  = 0;
            pwm = 1'b0;
        end else begin
            pwm = (ph < pwm_hi);
            ph  = (ph + 1 >= pwm_per) ? 0 : ph + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        we = 1'b1; addr = a; wdata = d;
        tick;
        we = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [1:0] a, input logic [15:0] exp);
        re = 1'b1; addr = a;
        tick;
        re = 1'b0;
        chk({tag, "_rvalid"}, {31'd0, rvalid}, 32'd1);
        chk(tag, {16'd0, rdata}, {16'd0, exp});
    endtask

    task automatic go;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic run(input int n, output int p);
        p = 0;
        repeat (n) begin
            tick;
            if (cend) p++;
        end
    endtask

    task automatic set_pwm(input int hi, input int per);
        pwm_en = 0;
        tick;
        pwm_hi = hi; pwm_per = per; pwm_en = 1;
    endtask

    task automatic wait_ph(input int p);
        int n = 0;
        while (ph != p && n < 300) begin
            tick;
            n++;
        end
        chk("wait_ph", {31'd0, ph == p}, 32'd1);
    endtask

    initial begin
        repeat (3) tick;
        rst_n = 1'b1;
        tick;

        // Reset state
        chk("rst_rdata",  {16'd0, rdata}, 32'd0);
        chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
        chk("rst_cend",   {31'd0, cend}, 32'd0);
        chk("rst_tout",   {31'd0, tout}, 32'd0);
        rd("rst_high",   2'd0, 16'h0000);
        tick;
        chk("rvalid_pulse", {31'd0, rvalid}, 32'd0);
        rd("rst_period", 2'd1, 16'h0000);
        rd("rst_stop",   2'd2, 16'h0000);
        rd("rst_status", 2'd3, 16'h0000);

        // Timeout with input held low: set exactly 65536 clocks after arming
        wr(2'd2, 16'd2);
        go;
        pulses = 0;
        for (int i = 1; i <= 65536; i++) begin
            tick;
            if (cend) pulses++;
            if (i == 65535) chk("to_early", {31'd0, tout}, 32'd0);
        end
        chk("to_set",    {31'd0, tout}, 32'd1);
        chk("to_nocend", pulses, 32'd0);
        rd("to_high",   2'd0, 16'h0000);
        rd("to_period", 2'd1, 16'h0000);
        rd("to_status", 2'd3, 16'h0004);

        // Basic measure 30/100, started mid-high so the partial pulse is skipped
        set_pwm(30, 100);
        wr(2'd2, 16'd1);
        wait_ph(11);
        go;
        chk("b_tout_clr", {31'd0, tout}, 32'd0);
        run(300, pulses);
        chk("b_cend", pulses, 32'd1);
        rd("b_high",   2'd0, 16'd30);
        rd("b_period", 2'd1, 16'd100);
        rd("b_status", 2'd3, 16'h0102);

        // Multi-period 10/25, 5 periods
        set_pwm(10, 25);
        wr(2'd2, 16'd5);
        go;
        run(250, pulses);
        chk("m_cend", pulses, 32'd1);
        rd("m_high",   2'd0, 16'd10);
        rd("m_period", 2'd1, 16'd25);
        rd("m_status", 2'd3, 16'h0502);

        // STOP written while busy only affects the next capture
        wr(2'd2, 16'd1);
        go;
        repeat (5) tick;
        wr(2'd2, 16'd3);
        run(100, pulses);
        chk("p_cend1", pulses, 32'd1);
        rd("p_status1", 2'd3, 16'h0102);
        rd("p_stop",    2'd2, 16'd3);
        go;
        run(150, pulses);
        chk("p_cend3", pulses, 32'd1);
        rd("p_status3", 2'd3, 16'h0302);
        wr(2'd0, 16'h1234);
        rd("p_ro_high", 2'd0, 16'd10);

        // Simultaneous read and write of STOP returns the old value
        re = 1'b1; we = 1'b1; addr = 2'd2; wdata = 16'h00ff;
        tick;
        re = 1'b0; we = 1'b0;
        chk("rw_old", {16'd0, rdata}, 32'd3);
        rd("rw_new", 2'd2, 16'h007f);

        // Reset in the middle of a high phase
        set_pwm(30, 100);
        wr(2'd2, 16'd3);
        go;
        repeat (120) tick;
        wait_ph(10);
        re = 1'b1; addr = 2'd3;
        tick;
        re = 1'b0;
        st = rdata;
        chk("mr_busy", {31'd0, st[0]}, 32'd1);
        rst_n = 1'b0;
        tick;
        tick;
        pwm_en = 0;
        rst_n = 1'b1;
        tick;
        chk("mr_rdata",  {16'd0, rdata}, 32'd0);
        chk("mr_rvalid", {31'd0, rvalid}, 32'd0);
        chk("mr_tout",   {31'd0, tout}, 32'd0);
        chk("mr_cend",   {31'd0, cend}, 32'd0);
        rd("mr_high",   2'd0, 16'h0000);
        rd("mr_period", 2'd1, 16'h0000);
        rd("mr_stop",   2'd2, 16'h0000);
        rd("mr_status", 2'd3, 16'h0000);
        go;
        tick;
        rd("mr_nostart", 2'd3, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
